pwm_duty_ramp: RTL and testbench

//  Upstream duty-cycle feeder for the pwm block: drives its val_i port.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_period_tick.sv | 29 ++
 rtl/pwm_duty_ramp.sv | 112 +++++++++++
 tb/tb_pwm_duty_ramp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for blocks slaved to a pwm period: ramp FSM states, default
// width and the saturating step-toward-target helper.
package pwm_pkg;

   localparam int unsigned DefWidth = 8;

   typedef enum logic [0:0] {StIdle, StRamp} ramp_state_e;

   // Moves cur toward tgt by at most stp; stp == 0 jumps. Never overshoots.
   function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] stp);
      logic [31:0] diff;
      diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
      if ((stp == 32'd0) || (diff <= stp)) begin
         return tgt;
      end else if (tgt > cur) begin
         return cur + stp;
      end else begin
         return cur - stp;
      end
   endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Mirror of the pwm period counter; strobes eop_o on the last count of each period.
module pwm_period_tick
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic eop_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = en_i ? cnt_q + WIDTH'(1) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign eop_o = en_i & (&cnt_q);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp feeding a pwm val_i: walks val_o toward an accepted target in
// bounded steps, updating only on pwm period boundaries.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tgt_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             tgt_valid_i,
   output logic             tgt_ready_o,
   output logic [WIDTH-1:0] val_o,
   output logic             busy_o,
   output logic             done_o
);

   ramp_state_e      state_q, state_d;
   logic [WIDTH-1:0] val_q, val_d, tgt_q, tgt_d, step_q, step_d, stepped;
   logic [DIV_W-1:0] div_q, div_d, dcnt_q, dcnt_d, div_eff;
   logic             done_q, done_d;
   logic             eop, accept;

   pwm_period_tick #(
      .WIDTH(WIDTH)
   ) u_tick (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i (en_i),
      .eop_o(eop)
   );

   assign tgt_ready_o = (state_q == StIdle) & en_i;
   assign accept      = tgt_valid_i & tgt_ready_o;
   assign div_eff     = (div_i == '0) ? DIV_W'(1) : div_i;
   assign stepped     = WIDTH'(step_toward(32'(val_q), 32'(tgt_q), 32'(step_q)));

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      div_d   = div_q;
      dcnt_d  = dcnt_q;
      done_d  = 1'b0;
      if (!en_i) begin
         // Disable abandons any ramp; the next one soft-starts from zero.
         state_d = StIdle;
         val_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  tgt_d  = tgt_i;
                  step_d = step_i;
                  div_d  = div_eff;
                  dcnt_d = div_eff - DIV_W'(1);
                  if (tgt_i == val_q) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = StRamp;
                  end
               end
            end
            StRamp: begin
               if (eop) begin
                  if (dcnt_q != '0) begin
                     dcnt_d = dcnt_q - DIV_W'(1);
                  end else begin
                     val_d  = stepped;
                     dcnt_d = div_q - DIV_W'(1);
                     if (stepped == tgt_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         val_q   <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
         div_q   <= '0;
         dcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         div_q   <= div_d;
         dcnt_q  <= dcnt_d;
         done_q  <= done_d;
      end
   end

   assign val_o  = val_q;
   assign busy_o = (state_q == StRamp);
   assign done_o = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp at WIDTH=4 with a companion pwm counter.
module tb_pwm_duty_ramp;

   localparam int unsigned W  = 4;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [W-1:0]  tgt = '0;
   logic [W-1:0]  step = '0;
   logic [DW-1:0] div = '0;
   logic          tgt_valid = 1'b0;
   logic          tgt_ready;
   logic [W-1:0]  val;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_val_q[$];
   int exp_done_q[$];
   logic [W-1:0] prev_val = '0;
   logic [W-1:0] pcnt;

   always #5 clk = ~clk;

   pwm_duty_ramp #(
      .WIDTH(W),
      .DIV_W(DW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .en_i       (en),
      .tgt_i      (tgt),
      .step_i     (step),
      .div_i      (div),
      .tgt_valid_i(tgt_valid),
      .tgt_ready_o(tgt_ready),
      .val_o      (val),
      .busy_o     (busy),
      .done_o     (done)
   );

   // Companion pwm counter: val_o may only change when this reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   pcnt <= '0;
      else if (!en) pcnt <= '0;
      else          pcnt <= pcnt + 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout/unexpected event, expected none (t=%0t)", name, $time);
   endtask

   // Monitor: pops expectations whenever val_o changes or done_o pulses.
   always @(negedge clk) begin
      if (val !== prev_val) begin
         if (exp_val_q.size() == 0) fail_now("unexpected_val_change");
         else check("val_seq", int'(val), exp_val_q.pop_front());
         check("pwm_cnt_at_update", int'(pcnt), 0);
         prev_val = val;
      end
      if (done) begin
         if (exp_done_q.size() == 0) fail_now("unexpected_done");
         else check("done_val", int'(val), exp_done_q.pop_front());
         check("busy_at_done", int'(busy), 0);
      end
   end

   task automatic send(input int t, input int s, input int d);
      bit ok = 1'b0;
      @(negedge clk);
      tgt = W'(t); step = W'(s); div = DW'(d); tgt_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (tgt_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) fail_now("send_ready_timeout");
      @(posedge clk);
      #1 tgt_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("done_timeout");
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   task automatic wait_val(input int v);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (val == W'(v)) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("wait_val_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset with en low
      #12;
      check("rst_val", int'(val), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(tgt_ready), 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) en = 1'b1;
      #1 check("ready_after_en", int'(tgt_ready), 1);

      // 2: up ramp 0 -> 10, step 3
      exp_val_q.push_back(3); exp_val_q.push_back(6);
      exp_val_q.push_back(9); exp_val_q.push_back(10);
      exp_done_q.push_back(10);
      send(10, 3, 1);
      wait_done();

      // 3: down ramp 10 -> 0, step 4, div 0 acts as 1
      exp_val_q.push_back(6); exp_val_q.push_back(2); exp_val_q.push_back(0);
      exp_done_q.push_back(0);
      send(0, 4, 0);
      wait_done();

      // 4: jump with div 2, then same target again
      exp_val_q.push_back(8);
      exp_done_q.push_back(8);
      send(8, 0, 2);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pcnt == '0) break;
      end
      check("div2_hold_first_eop", int'(val), 0);
      wait_done();
      exp_done_q.push_back(8);
      send(8, 1, 1);
      wait_done();
      check("same_tgt_no_busy", int'(busy), 0);

      // 5: soft-start from 0 to 12, en dropped after third step, held request
      exp_val_q.push_back(0);
      @(negedge clk) en = 1'b0;
      @(negedge clk) en = 1'b1;
      exp_val_q.push_back(2); exp_val_q.push_back(4); exp_val_q.push_back(6);
      send(12, 2, 1);
      @(negedge clk);
      tgt = W'(5); tgt_valid = 1'b1;
      wait_val(6);
      check("busy_mid_ramp", int'(busy), 1);
      check("ready_mid_ramp", int'(tgt_ready), 0);
      exp_val_q.push_back(0);
      en = 1'b0;
      @(negedge clk);
      check("en_drop_val", int'(val), 0);
      check("en_drop_busy", int'(busy), 0);
      @(negedge clk);
      exp_val_q.push_back(2); exp_val_q.push_back(4); exp_val_q.push_back(5);
      exp_done_q.push_back(5);
      en = 1'b1;
      @(posedge clk);
      #1 tgt_valid = 1'b0;
      wait_done();

      // 6: async reset mid-ramp, then full-scale clamp
      exp_val_q.push_back(6); exp_val_q.push_back(7);
      send(15, 1, 1);
      wait_val(7);
      exp_val_q.push_back(0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_val", int'(val), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      @(negedge clk) rst_n = 1'b1;
      exp_val_q.push_back(7); exp_val_q.push_back(14); exp_val_q.push_back(15);
      exp_done_q.push_back(15);
      send(15, 7, 1);
      wait_done();

      repeat (20) @(negedge clk);
      check("val_queue_drained", exp_val_q.size(), 0);
      check("done_queue_drained", exp_done_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
